// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads program bytes over a req/ack bus and
// buffers them in a prefetch FIFO. Define FETCH_BYPASS_EN for zero-latency ack bypass.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    output logic [7:0]        instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [7:0]        buf_data_q [DEPTH];
    logic [ADDR_W-1:0] buf_pc_q   [DEPTH];

    logic fifo_empty;
    logic bypass;
    logic push;
    logic pop;
    logic issue;

    assign fifo_empty = (count_q == '0);

`ifdef FETCH_BYPASS_EN
    // An ack landing on an empty FIFO is forwarded straight to the consumer.
    assign bypass      = ena && fifo_empty && (state_q == ST_REQ) && mem_ack && !jump_en;
    assign instr_valid = !fifo_empty || bypass;
    assign instr_data  = bypass ? mem_rdata : buf_data_q[rd_ptr_q];
    assign instr_pc    = bypass ? addr_q : buf_pc_q[rd_ptr_q];
`else
    assign bypass      = 1'b0;
    assign instr_valid = !fifo_empty;
    assign instr_data  = buf_data_q[rd_ptr_q];
    assign instr_pc    = buf_pc_q[rd_ptr_q];
`endif

    // Jump wins over both pop and push; a bypassed byte that is consumed is never stored.
    assign pop  = ena && !jump_en && instr_ready && !fifo_empty;
    assign push = ena && !jump_en && (state_q == ST_REQ) && mem_ack && !(bypass && instr_ready);

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign busy     = req_q || instr_valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_d    = req_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        issue    = 1'b0;
        if (ena) begin
            if (jump_en) begin
                count_d  = '0;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                pc_d     = jump_addr;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (push && !pop) begin
                    count_d = count_q + CNT_W'(1);
                end else if (pop && !push) begin
                    count_d = count_q - CNT_W'(1);
                end
                if ((state_q == ST_REQ) && mem_ack) pc_d = pc_q + ADDR_W'(1);
            end
            issue = !halt && (count_d < FULL_CNT);
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        addr_d  = pc_d;
                    end
                end
                ST_REQ, ST_DISCARD: begin
                    // The bus transfer always runs to its ack, even if its data is dropped.
                    if (mem_ack) begin
                        if (issue) begin
                            state_d = ST_REQ;
                            addr_d  = pc_d;
                        end else begin
                            state_d = ST_IDLE;
                            req_d   = 1'b0;
                        end
                    end else if (jump_en) begin
                        state_d = ST_DISCARD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            req_q    <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) begin
                buf_data_q[wr_ptr_q] <= mem_rdata;
                buf_pc_q[wr_ptr_q]   <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based fetch model compared every cycle,
// plus directed phases with hand-computed literal expectations.
module tb_fetch_unit;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 2;
    localparam logic [7:0]  RST_PC = 8'hFE;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              instr_valid;
    logic [7:0]        instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              halt;
    logic              busy;

    fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RST_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .halt       (halt),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int lat    = 1;

    // Model state: expected FIFO contents as {pc, data}, expected bus request.
    logic [15:0] mq[$];
    logic [15:0] dlv_q[$];
    logic        m_req;
    logic        m_drop;
    logic [7:0]  m_addr;
    logic [7:0]  m_pc;
    logic [15:0] head;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: acks `lat` cycles after a request becomes visible, data = addr ^ A5.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n || !mem_req) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (!ena) begin
                mem_ack = 1'b0;
            end else if (wait_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ 8'hA5;
                wait_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    // Behavioural fetch model, advanced on each active edge.
    initial begin
        m_req  = 1'b0;
        m_drop = 1'b0;
        m_addr = 8'h00;
        m_pc   = RST_PC;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_req  = 1'b0;
                m_drop = 1'b0;
                m_addr = 8'h00;
                m_pc   = RST_PC;
                mq.delete();
            end else if (ena) begin
                logic acked;
                acked = m_req && mem_ack;
                if (!jump_en && instr_ready && mq.size() > 0) void'(mq.pop_front());
                if (acked) begin
                    if (!jump_en && !m_drop) begin
                        mq.push_back({m_addr, mem_rdata});
                        m_pc = m_pc + 8'd1;
                    end
                    m_drop = 1'b0;
                end
                if (jump_en) begin
                    mq.delete();
                    m_pc = jump_addr;
                    if (m_req && !acked) m_drop = 1'b1;
                end
                if (!m_req || acked) begin
                    if (!halt && mq.size() < DEPTH) begin
                        m_req  = 1'b1;
                        m_addr = m_pc;
                    end else begin
                        m_req = 1'b0;
                    end
                end
            end
        end
    end

    // Cycle compare against the model; also log bytes the consumer takes.
    initial begin
        forever begin
            @(negedge clk);
            check("mem_req", 32'(mem_req), 32'(m_req));
            if (m_req) check("mem_addr", 32'(mem_addr), 32'(m_addr));
            check("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                head = mq[0];
                check("instr_pc", 32'(instr_pc), 32'(head[15:8]));
                check("instr_data", 32'(instr_data), 32'(head[7:0]));
            end
            check("busy", 32'(busy), 32'(m_req || (mq.size() != 0)));
            if (rst_n && ena && !jump_en && instr_valid && instr_ready)
                dlv_q.push_back({instr_pc, instr_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr_data"}, 32'(instr_data), 32'd0);
        check({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        tick();
        tick();
        rst_n = 1'b1;
        dlv_q.delete();
    endtask

    task automatic check_dlv(input string tag, input int idx, input logic [7:0] pc,
                             input logic [7:0] data);
        logic [15:0] e;
        check({tag, "_dlv_avail"}, 32'(dlv_q.size() > idx), 32'd1);
        if (dlv_q.size() > idx) begin
            e = dlv_q[idx];
            check({tag, "_dlv_pc"}, 32'(e[15:8]), 32'(pc));
            check({tag, "_dlv_data"}, 32'(e[7:0]), 32'(data));
        end
    endtask

    initial begin
        logic [7:0] a_pc  [4];
        logic [7:0] a_dat [4];
        logic [7:0] p;
        a_pc  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        a_dat = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
        rst_n       = 1'b1;
        ena         = 1'b1;
        halt        = 1'b0;
        instr_ready = 1'b1;
        jump_en     = 1'b0;
        jump_addr   = 8'h00;
        #1;

        // Free run with 1-cycle memory latency; PC wraps FE, FF, 00, 01.
        lat = 1;
        do_reset("rst");
        repeat (12) tick();
        for (int i = 0; i < 4; i++) check_dlv("wrap", i, a_pc[i], a_dat[i]);

        // Consumer stalled: FIFO fills with two bytes, then one pop frees a slot.
        lat         = 0;
        instr_ready = 1'b0;
        do_reset("rst_b");
        repeat (8) tick();
        check("full_mem_req", 32'(mem_req), 32'd0);
        check("full_valid", 32'(instr_valid), 32'd1);
        check("full_head_pc", 32'(instr_pc), 32'hFE);
        check("full_head_data", 32'(instr_data), 32'h5B);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("refill_mem_req", 32'(mem_req), 32'd1);
        check("refill_mem_addr", 32'(mem_addr), 32'h00);
        check("refill_head_pc", 32'(instr_pc), 32'hFF);
        check("refill_head_data", 32'(instr_data), 32'h5A);
        tick();
        check("refull_mem_req", 32'(mem_req), 32'd0);
        instr_ready = 1'b1;
        repeat (4) tick();

        // Jump while the request to FF is outstanding: its data must be dropped.
        lat = 2;
        do_reset("rst_c");
        repeat (4) tick();
        jump_en   = 1'b1;
        jump_addr = 8'h40;
        tick();
        jump_en = 1'b0;
        check("disc_mem_req", 32'(mem_req), 32'd1);
        check("disc_mem_addr", 32'(mem_addr), 32'hFF);
        check("disc_valid", 32'(instr_valid), 32'd0);
        tick();
        tick();
        check("redir_mem_addr", 32'(mem_addr), 32'h40);
        repeat (6) tick();
        check_dlv("jump", 0, 8'h40, 8'hE5);

        // Halt mid-request: in-flight byte delivered, then the bus stays idle.
        lat = 2;
        do_reset("rst_d");
        tick();
        tick();
        halt = 1'b1;
        tick();
        tick();
        check("halt_mem_req", 32'(mem_req), 32'd0);
        check("halt_valid", 32'(instr_valid), 32'd1);
        check("halt_pc", 32'(instr_pc), 32'hFE);
        repeat (4) tick();
        check("halt_idle_req", 32'(mem_req), 32'd0);
        check("halt_drained", 32'(instr_valid), 32'd0);
        halt = 1'b0;
        tick();
        check("unhalt_mem_req", 32'(mem_req), 32'd1);
        check("unhalt_mem_addr", 32'(mem_addr), 32'hFF);
        check("halt_dlv_count", 32'(dlv_q.size()), 32'd1);
        check_dlv("halt", 0, 8'hFE, 8'h5B);

        // Reset pulse mid-request, then a full-rate stream with an enable gap.
        lat = 0;
        do_reset("rst_mid");
        tick();
        check("restart_mem_req", 32'(mem_req), 32'd1);
        check("restart_mem_addr", 32'(mem_addr), 32'hFE);
        repeat (5) tick();
        ena = 1'b0;
        repeat (3) begin
            tick();
            check("frz_mem_req", 32'(mem_req), 32'd1);
            check("frz_mem_addr", 32'(mem_addr), 32'h03);
            check("frz_valid", 32'(instr_valid), 32'd1);
            check("frz_pc", 32'(instr_pc), 32'h02);
            check("frz_data", 32'(instr_data), 32'hA7);
        end
        ena = 1'b1;
        repeat (5) tick();
        check("stream_count", 32'(dlv_q.size()), 32'd9);
        for (int i = 0; i < dlv_q.size(); i++) begin
            p = RST_PC + 8'(i);
            check_dlv("stream", i, p, p ^ 8'hA5);
        end

        // Jump coinciding with an ack: that byte is dropped, next fetch at target.
        dlv_q.delete();
        jump_en   = 1'b1;
        jump_addr = 8'h80;
        tick();
        jump_en = 1'b0;
        check("jack_mem_req", 32'(mem_req), 32'd1);
        check("jack_mem_addr", 32'(mem_addr), 32'h80);
        check("jack_valid", 32'(instr_valid), 32'd0);
        repeat (4) tick();
        check_dlv("jack", 0, 8'h80, 8'h25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the CPU control block. It owns the program counter and issues byte reads to program memory over a req/ack bus. Returned instruction bytes are buffered in a small prefetch FIFO and presented to the control block over a valid/ready handshake. Jumps from the control block flush the buffer and redirect the PC.

## Interface
Parameters:
- ADDR_W, 8, program-counter / memory address width
- DEPTH, 2, prefetch FIFO entries; power of two, 2..8
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low freezes all state, no new requests
- mem_req  out  1  read request to program memory
- mem_addr  out  ADDR_W  read address; stable while mem_req high
- mem_ack  in  1  one-cycle read completion; mem_rdata valid same cycle
- mem_rdata  in  8  instruction byte
- instr_valid  out  1  FIFO head valid
- instr_data  out  8  FIFO head byte
- instr_pc  out  ADDR_W  address the head byte was fetched from
- instr_ready  in  1  control block accepts head this cycle
- jump_en  in  1  redirect fetch (one-cycle pulse)
- jump_addr  in  ADDR_W  redirect target
- halt  in  1  stop issuing new requests
- busy  out  1  request in flight or FIFO non-empty

## Operation
- State machine: IDLE, REQ, DISCARD.
- IDLE -> REQ when ena, !halt, and (count + 0) < DEPTH; mem_addr <= pc, mem_req <= 1.
- REQ: hold mem_req/mem_addr until mem_ack. On ack: push {mem_rdata, mem_addr}, pc <= pc + 1 (wraps 2^ADDR_W-1 -> 0); go REQ again if space remains after push and !halt, else IDLE.
- Back-to-back fetch: a new request issues the cycle after ack; mem_req may stay high continuously across requests with updated mem_addr.
- Pop: instr_valid && instr_ready removes head.
- Push and pop in the same cycle: count unchanged; allowed when full (pop makes room).
- Jump: FIFO flushed (count <= 0), pc <= jump_addr. If a request is in flight with no ack this cycle: go DISCARD; bus request continues at old address, its ack data is dropped, then next request goes to jump_addr. If ack coincides with jump: data dropped, next request at jump_addr. Jump beats simultaneous pop and push.
- halt: no new request issued; in-flight request completes normally and is pushed; FIFO still drains.
- ena low: all registers hold, including FSM; mem_req holds its value (bus must not be abandoned mid-request).
- busy = mem_req || instr_valid.

## Timing
- Reset (async assert, sync-released by system): pc = RESET_PC, state IDLE, count 0, mem_req 0, mem_addr 0, instr_valid 0, instr_data 0, instr_pc 0, busy 0.
- First mem_req high in first cycle after rst_n rises with ena high (registered, i.e. visible cycle 1).
- mem_ack at cycle N -> instr_valid high at cycle N+1 (registered FIFO output).
- Jump at cycle N with nothing in flight -> mem_req at jump_addr visible cycle N+1; instr_valid low at N+1.
- Full FIFO: mem_req stays low until a pop frees an entry; request issues cycle after pop.
- Sustained throughput: one byte per cycle when memory acks in the request cycle and consumer always ready.

## Configuration
- FETCH_BYPASS_EN defined: when FIFO empty and not in DISCARD, mem_ack data drives instr_data/instr_pc combinationally with instr_valid high in the ack cycle; if instr_ready also high it is consumed and not pushed. Zero-cycle fetch-to-decode latency.
- Undefined: all outputs registered; latency strictly ack N -> valid N+1.

## Test plan
- Reset then ena=1, memory acks 1 cycle after req with data = addr ^ 8'hA5 -> addresses 0,1,2,... issued; instr_data 8'hA5, 8'hA4, ... with matching instr_pc.
- instr_ready held low, DEPTH=2 -> exactly two requests (addr 0,1), mem_req then low; one pop -> request addr 2 next cycle.
- Jump to 8'h40 while request to addr 3 outstanding, ack 2 cycles later -> addr 3 data never appears, next mem_addr 8'h40, first instr_pc 8'h40.
- RESET_PC=8'hFE, free-run -> fetched pcs FE, FF, 00, 01 (wrap).
- halt asserted mid-request -> in-flight byte delivered, no further mem_req until halt low; rst_n pulsed mid-request -> all outputs zero immediately, pc back to RESET_PC.
- ena low for 3 cycles mid-stream -> mem_req/mem_addr/instr outputs unchanged, no pops; resumes without lost or duplicated bytes.
